// File: rtl/lab6_pkg.sv
// Shared constants for the lab6 CPU: instruction width, HALT encoding and loader states.
// Pure declarations; no logic.
package lab6_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] HALT_WORD = 16'h0001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    FULL = ST_FULL
  } ld_state_t;

endpackage

// File: rtl/iram_load_fsm.sv
// Program-load sequencer: write pointer, word count and overflow flag; one word per cycle.
// Write strobe is issued in the accepting cycle; LD_READY is low outside LOAD, FULL drops data.
module iram_load_fsm
  import lab6_pkg::*;
#(
  parameter int DEPTH = 128
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       LD_START,
  input  logic                       LD_VALID,
  input  logic                       LD_LAST,
  output logic                       LD_READY,
  output logic                       BUSY,
  output logic                       wr_en,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH):0]     LD_COUNT,
  output logic                       LD_ERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  ld_state_t        state, state_nxt;
  logic [PTR_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             err, err_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    err_nxt   = err;
    wr_en     = 1'b0;
    LD_READY  = 1'b0;
    BUSY      = 1'b0;
    case (state)
      IDLE: begin
        // LD_LAST alone means nothing here; START wins if both arrive together.
        if (LD_START) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        LD_READY = 1'b1;
        BUSY     = 1'b1;
        if (LD_START) begin
          ptr_nxt = '0;
          cnt_nxt = '0;
        end else if (LD_VALID) begin
          wr_en = 1'b1;
          if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
          if (ptr != PTR_MAX) ptr_nxt = ptr + PTR_W'(1);
          if (LD_LAST)
            state_nxt = IDLE;
          else if (ptr == PTR_MAX)
            state_nxt = FULL;
        end
      end
      FULL: begin
        // Every slot is written; further data is an overflow until the host closes the load.
        BUSY = 1'b1;
        if (LD_START) begin
          state_nxt = LOAD;
          ptr_nxt   = '0;
          cnt_nxt   = '0;
        end else if (LD_VALID) begin
          err_nxt = 1'b1;
        end else if (LD_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_addr  = ptr;
  assign LD_COUNT = cnt;
  assign LD_ERR   = err;

endmodule

// File: rtl/lab6iram_loadable.sv
// Instruction memory with runtime load port; combinational fetch on a byte address (0-cycle).
// Loader accepts one word per cycle while LD_READY; fetch returns HALT whenever a load is active.
module lab6iram_loadable
  import lab6_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = INSTR_W,
  parameter int DEPTH  = 128
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        Q,
  output logic                     MISALIGN,
  output logic                     BUSY,
  input  logic                     LD_START,
  input  logic                     LD_VALID,
  output logic                     LD_READY,
  input  logic [DATA_W-1:0]        LD_DATA,
  input  logic                     LD_LAST,
  output logic [$clog2(DEPTH):0]   LD_COUNT,
  output logic                     LD_ERR
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] HALT = DATA_W'(HALT_WORD);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;
  logic [ADDR_W-2:0] word_idx;

  iram_load_fsm #(
    .DEPTH (DEPTH)
  ) u_fsm (
    .CLK      (CLK),
    .RESET    (RESET),
    .LD_START (LD_START),
    .LD_VALID (LD_VALID),
    .LD_LAST  (LD_LAST),
    .LD_READY (LD_READY),
    .BUSY     (BUSY),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .LD_COUNT (LD_COUNT),
    .LD_ERR   (LD_ERR)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= HALT;
    end else if (wr_en) begin
      mem[wr_addr] <= LD_DATA;
    end
  end

  // Byte address to word index; bit 0 only feeds the misalignment flag.
  assign word_idx = ADDR[ADDR_W-1:1];
  assign MISALIGN = ADDR[0];
  assign Q        = BUSY ? HALT : mem[word_idx];

endmodule

// File: tb/tb_lab6iram_loadable.sv
// Directed and randomized bench for lab6iram_loadable against a word-level load model.
module tb_lab6iram_loadable;

  localparam int DEPTH = 128;
  localparam logic [15:0] HALT = 16'h0001;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [7:0]  ADDR = '0;
  logic [15:0] Q;
  logic        MISALIGN, BUSY, LD_READY, LD_ERR;
  logic        LD_START = 1'b0, LD_VALID = 1'b0, LD_LAST = 1'b0;
  logic [15:0] LD_DATA = '0;
  logic [7:0]  LD_COUNT;

  int total = 0;
  int bad   = 0;

  // Reference: memory image, whether a load session is open, words accepted, overflow seen.
  logic [15:0] mdl_mem [DEPTH];
  bit          mdl_loading;
  int          mdl_cnt;
  bit          mdl_err;
  logic [15:0] words [DEPTH];

  lab6iram_loadable dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .ADDR     (ADDR),
    .Q        (Q),
    .MISALIGN (MISALIGN),
    .BUSY     (BUSY),
    .LD_START (LD_START),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .LD_DATA  (LD_DATA),
    .LD_LAST  (LD_LAST),
    .LD_COUNT (LD_COUNT),
    .LD_ERR   (LD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [15:0] exp_q;
    exp_q = mdl_loading ? HALT : mdl_mem[ADDR[7:1]];
    chk({tag, ".q"}, 32'(Q), 32'(exp_q));
    chk({tag, ".busy"}, 32'(BUSY), 32'(mdl_loading));
    chk({tag, ".ready"}, 32'(LD_READY), 32'(mdl_loading && mdl_cnt < DEPTH));
    chk({tag, ".count"}, 32'(LD_COUNT), 32'(mdl_cnt));
    chk({tag, ".err"}, 32'(LD_ERR), 32'(mdl_err));
    chk({tag, ".misalign"}, 32'(MISALIGN), 32'(ADDR[0]));
  endtask

  // Apply one cycle of loader inputs, advance the model by the same rules, sample after the edge.
  task automatic cycle(input bit rst, input bit st, input bit vl, input bit lt, input logic [15:0] d);
    RESET = rst; LD_START = st; LD_VALID = vl; LD_LAST = lt; LD_DATA = d;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = HALT;
      mdl_loading = 0; mdl_cnt = 0; mdl_err = 0;
    end else if (!mdl_loading) begin
      if (st) begin mdl_loading = 1; mdl_cnt = 0; end
    end else if (st) begin
      mdl_cnt = 0;
    end else if (mdl_cnt < DEPTH) begin
      if (vl) begin
        mdl_mem[mdl_cnt] = d;
        mdl_cnt++;
        if (lt) mdl_loading = 0;
      end
    end else if (vl) begin
      mdl_err = 1;
    end else if (lt) begin
      mdl_loading = 0;
    end
    @(posedge CLK);
    #1;
    RESET = 0; LD_START = 0; LD_VALID = 0; LD_LAST = 0;
  endtask

  task automatic probe(input logic [7:0] a, input string tag);
    @(negedge CLK);
    ADDR = a;
    #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 16'hxxxx;

    // 1: reset fills HALT everywhere
    cycle(1, 0, 0, 0, 16'h0);
    for (int a = 0; a < 256; a += 2) probe(8'(a), "reset_fill");

    // 2/3: short load, fetch gated while busy
    cycle(0, 1, 0, 0, 16'h0);
    probe(8'h00, "gated_start");
    cycle(0, 0, 1, 0, 16'h2078);
    probe(8'h00, "gated_mid");
    cycle(0, 0, 1, 0, 16'h2279);
    cycle(0, 0, 1, 1, 16'h0001);
    chk("short_count", 32'(LD_COUNT), 32'd3);
    chk("short_busy", 32'(BUSY), 32'd0);
    probe(8'h02, "short_a2");
    chk("short_q2", 32'(Q), 32'h2279);
    probe(8'h06, "short_a6");
    probe(8'h00, "short_a0");
    chk("short_q0", 32'(Q), 32'h2078);

    // 4: fill all 128 slots, overflow, then close
    cycle(0, 1, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH; i++) begin
      words[i] = 16'($urandom);
      cycle(0, 0, 1, 0, words[i]);
    end
    check_all("full_reached");
    cycle(0, 0, 1, 0, 16'hdead);
    check_all("full_overflow");
    chk("full_err", 32'(LD_ERR), 32'd1);
    chk("full_ready", 32'(LD_READY), 32'd0);
    cycle(0, 0, 0, 1, 16'h0);
    probe(8'd254, "full_last");
    chk("full_last_word", 32'(Q), 32'(words[127]));
    for (int k = 0; k < 16; k++) probe(8'($urandom), "full_rand");

    // 5: reset aborts a load in flight; START during LOAD restarts at index 0
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'h1111);
    cycle(0, 0, 1, 0, 16'h2222);
    cycle(1, 0, 1, 0, 16'h3333);
    check_all("abort");
    chk("abort_count", 32'(LD_COUNT), 32'd0);
    chk("abort_err", 32'(LD_ERR), 32'd0);
    for (int k = 0; k < 8; k++) probe(8'($urandom) & 8'hfe, "abort_fill");
    cycle(0, 1, 0, 0, 16'h0);
    cycle(0, 0, 1, 0, 16'h4444);
    cycle(0, 0, 1, 0, 16'h5555);
    cycle(0, 1, 1, 0, 16'h6666);
    check_all("restart");
    chk("restart_count", 32'(LD_COUNT), 32'd0);
    cycle(0, 0, 1, 0, 16'h7777);
    cycle(0, 0, 1, 0, 16'h8888);
    cycle(0, 0, 1, 1, 16'h9999);
    probe(8'h00, "restart_a0");
    chk("restart_q0", 32'(Q), 32'h7777);

    // START and LAST together in IDLE: START wins
    cycle(0, 1, 0, 1, 16'h0);
    check_all("start_last_idle");
    cycle(0, 0, 1, 1, 16'habcd);

    // 6: misaligned fetch
    probe(8'h05, "mis5");
    chk("mis5_flag", 32'(MISALIGN), 32'd1);
    chk("mis5_q", 32'(Q), 32'h9999);
    probe(8'h04, "mis4");
    chk("mis4_flag", 32'(MISALIGN), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ADDR = 8'($urandom);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, 16'($urandom));
      check_all("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
